imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the pipeline's immediate decode path: packs a signed 32-bit immediate plus register, funct and opcode fields into a 32-bit RV32I instruction word, using the same ImmSel encoding as decode.
- Sits in the instruction-injection/test-stimulus path ahead of instruction memory.
- Valid/ready input, small output FIFO with backpressure, per-entry range/alignment error flag, accepted-instruction counter.

Parameters:
- FIFO_DEPTH, 2, output FIFO entries; power of two, >= 2.
- CNT_W, 16, width of enc_count.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- ImmSel  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101-111 R (no immediate)
- opcode  in  7  inst[6:0]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  inst[14:12]
- funct7  in  7  R-type only
- imm  in  32  signed byte-offset/value to encode
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer pops head when out_valid & out_ready
- inst  out  32  encoded instruction at FIFO head
- err  out  1  head entry's immediate was out of range or misaligned
- enc_count  out  CNT_W  accepted-request count, wraps

Behaviour:
- Clocking: single clock; reset is synchronous, active-high.
- Reset values: FIFO emptied, out_valid=0, inst=0, err=0, enc_count=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all queued entries; no partial pop.
- Packing (combinational, written into FIFO on accept):
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - U: {imm[31:12], rd, opcode}
  - R (101-111): {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored.
  - Fields not used by a format are ignored.
- Range rules (err=1 when violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: never errors.
  - On error the entry is still enqueued, with truncated bits as packed above.
- Round-trip property: for any legal input, decoding inst with the same ImmSel returns imm exactly.
- Latency: accept in cycle N -> out_valid=1 with that inst in cycle N+1 if the FIFO was empty. Strict FIFO order.
- Handshake:
  - in_ready = (occupancy < FIFO_DEPTH); it does not depend on out_ready.
  - inst/err stay stable while out_valid & !out_ready.
- Simultaneous push and pop: allowed when not full; occupancy unchanged. Full with pop: no push that cycle because in_ready=0.
- Empty: out_valid=0; inst/err hold their last values and are don't-care.
- Counter: enc_count increments by 1 per accepted request and wraps from 2^CNT_W-1 to 0.

Optional Feature:
- IMM_ENC_CHECK_EN
  - Defined: range/alignment checking as above; err is stored per FIFO entry.
  - Undefined: checks not built; err tied 0; packing unchanged (silent truncation).

Test Plan:
- Reset, then I: opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 -> next cycle out_valid=1, inst=0x00500093, err=0, enc_count=1.
- S: opcode=0100011, funct3=010, rs1=1, rs2=2, imm=8 -> 0x0020A423. B: opcode=1100011, rs1=rs2=0, funct3=0, imm=-4 -> 0xFE000EE3.
- J: opcode=1101111, rd=1, imm=0x800 -> 0x001000EF. U: opcode=0110111, rd=5, imm=0x12345000 -> 0x123452B7.
- With IMM_ENC_CHECK_EN defined:
  - I, rd=1, imm=2048 -> inst=0x80000093, err=1.
  - B, imm=6 -> err=0; B, imm=3 -> err=1.
  - U, imm=0x00001001 -> err=1.
- out_ready=0, offer 3 back-to-back requests, FIFO_DEPTH=2 -> in_ready=0 after the 2nd accept. Raise out_ready -> the three entries emerge in order with no loss or duplication; enc_count=3.
- FIFO holding 2 entries, assert rst for 1 cycle -> out_valid=0, enc_count=0, in_ready=1. The next request emerges alone.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: packs a signed 32-bit immediate plus register/funct/opcode
// fields into an RV32I instruction word (inverse of the decode immediate
// path, same ImmSel encoding) and queues it in a small output FIFO.
//
// Optional build macro: IMM_ENC_CHECK_EN
//   defined   -> immediate range/alignment checks built, err stored per entry
//   undefined -> no checks, err tied 0, packing unchanged (silent truncation)
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  request handshake; in_ready = FIFO not full
//   ImmSel          000 I, 001 S, 010 B, 011 J, 100 U, 101-111 R
//   opcode, rd, rs1, rs2, funct3, funct7, imm   instruction fields
//   out_valid/ready FIFO head handshake
//   inst, err       head entry's encoded word and range/alignment error flag
//   enc_count       accepted-request count, wraps
module imm_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ImmSel,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [CNT_W-1:0] enc_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    localparam logic [2:0] SEL_I = 3'b000;
    localparam logic [2:0] SEL_S = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_J = 3'b011;
    localparam logic [2:0] SEL_U = 3'b100;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic          push;
    logic          pop;
    logic [31:0]   packed_inst;

    assign in_ready  = (occ < OW'(FIFO_DEPTH));
    assign out_valid = (occ != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign inst      = mem[rd_ptr];

    // Field packing; formats not using a field simply drop it.
    always_comb begin
        packed_inst = '0;
        case (ImmSel)
            SEL_I:   packed_inst = {imm[11:0], rs1, funct3, rd, opcode};
            SEL_S:   packed_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            SEL_B:   packed_inst = {imm[12], imm[10:5], rs2, rs1, funct3,
                                    imm[4:1], imm[11], opcode};
            SEL_J:   packed_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            SEL_U:   packed_inst = {imm[31:12], rd, opcode};
            default: packed_inst = {funct7, rs2, rs1, funct3, rd, opcode};
        endcase
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            enc_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= packed_inst;
                wr_ptr      <= wr_ptr + 1'b1;
                enc_count   <= enc_count + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef IMM_ENC_CHECK_EN
    logic                  range_err;
    logic [FIFO_DEPTH-1:0] err_mem;

    // A field of width w holds the value only if all bits above w-1 are
    // copies of the sign bit, i.e. all equal from the top down to w-1.
    always_comb begin
        range_err = 1'b0;
        case (ImmSel)
            SEL_I, SEL_S: range_err = !((&imm[31:11]) || !(|imm[31:11]));
            SEL_B:        range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            SEL_J:        range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            SEL_U:        range_err = (imm[11:0] != 12'h000);
            default:      range_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)       err_mem         <= '0;
        else if (push) err_mem[wr_ptr] <= range_err;
    end

    assign err = err_mem[rd_ptr];
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder: reset state, each format's packing,
// range/alignment flags (when IMM_ENC_CHECK_EN is defined), backpressure
// ordering and reset mid-operation.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ImmSel;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic        err;
    logic [15:0] enc_count;

    int n_vec  = 0;
    int n_fail = 0;

`ifdef IMM_ENC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    imm_encoder #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ImmSel(ImmSel), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .err(err),
        .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
        ImmSel = sel; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im;
    endtask

    // One request with out_ready=1: accepted on the next edge, visible at
    // the head one cycle later, then popped on the following edge.
    task automatic send(input string tag, input logic [2:0] sel, input logic [6:0] op,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                        input logic [31:0] exp_inst, input logic exp_err);
        set_req(sel, op, d, s1, s2, f3, f7, im);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".inst"}, inst, exp_inst);
        chk({tag, ".err"}, 32'(err), 32'(exp_err & CHK));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [31:0] got_q[$];
    logic [31:0] exp_bp[3];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_req(3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.inst", inst, 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.cnt", 32'(enc_count), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Format packing
        send("I", 3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        chk("I.cnt", 32'(enc_count), 32'd1);
        send("S", 3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423, 1'b0);
        send("B", 3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE000EE3, 1'b0);
        send("J", 3'b011, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h001000EF, 1'b0);
        send("U", 3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        send("R", 3'b101, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 1'b0);
        // Range/alignment boundaries
        send("I2048", 3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1);
        send("Im2048", 3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h80000093, 1'b0);
        send("B6", 3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h00000363, 1'b0);
        send("B3", 3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, 1'b1);
        send("U1001", 3'b100, 7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'h00001037, 1'b1);
        chk("cnt11", 32'(enc_count), 32'd11);
        chk("empty", 32'(out_valid), 32'd0);

        // Backpressure: three back-to-back requests, consumer stalled
        do_reset();
        exp_bp[0] = 32'h00100093; exp_bp[1] = 32'h00200093; exp_bp[2] = 32'h00300093;
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_req(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(posedge clk); #1;
        set_req(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        @(posedge clk); #1;
        set_req(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        chk("bp.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp.hold_inst", inst, exp_bp[0]);
        chk("bp.hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            logic acc;
            acc = in_valid & in_ready;
            if (out_valid) got_q.push_back(inst);
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        chk("bp.n_out", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < got_q.size()) chk($sformatf("bp.out%0d", i), got_q[i], exp_bp[i]);
        chk("bp.cnt", 32'(enc_count), 32'd3);

        // Reset with two queued entries
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_req(3'b000, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        @(posedge clk); @(posedge clk); #1;
        chk("pre_rst.full", 32'(in_ready), 32'd0);
        do_reset();
        chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst.cnt", 32'(enc_count), 32'd0);
        chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send("post_rst", 3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
        chk("post_rst.alone", 32'(out_valid), 32'd0);
        chk("post_rst.cnt", 32'(enc_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
